// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default reset PC and FIFO entry type for the fetch unit
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO of fetched {pc, instr}; flush empties it, rst also zeroes storage
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic wptr, rptr;
  assign head = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= !wptr;
      end
      if (pop) rptr <= !rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/issue/redirect control feeding a 2-entry skid FIFO to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic               fetch_fault
);
  logic [XLEN-1:0] pc, inflight_pc, rpc;
  logic inflight, deq, issue, halt;
  logic [1:0] count;
  fetch_entry_t head;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault;
  always_ff @(posedge clk) fault <= rst ? 1'b0 : fault | (redirect_valid && redirect_pc[1:0] != 2'b00);
  assign halt = fault;
  assign fetch_fault = fault;
`else
  assign halt = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  assign rpc = redirect_pc & ~32'h3;
  assign imem_addr = pc & ~32'h3;
  assign dec_valid = count != 2'd0;
  assign deq = dec_valid && dec_ready;
  // Occupancy after this cycle's dequeue, counting the word still in flight, must leave room
  assign issue = !redirect_valid && !halt && (({1'b0, count} + 3'(inflight) - 3'(deq)) < 3'd2);
  assign dec_instr = head.instr;
  assign dec_pc = head.pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      pc <= redirect_valid ? rpc : issue ? pc + 32'd4 : pc;
    end
  end
  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (inflight && !redirect_valid),
    .push_data ('{pc: inflight_pc, instr: imem_data}),
    .pop       (deq),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: cycle table for fetch/stall/redirect/reset plus random-stall stream scoreboard
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, dec_ready, dec_valid, fetch_fault;
  logic [31:0] redirect_pc, imem_addr, imem_data, dec_instr, dec_pc;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic rst, rdy, rv;
    logic [31:0] rpc;
    logic ev;
    logic [31:0] epc, eaddr;
    logic ef;
  } vec_t;
  vec_t tv[38];
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= imem_addr ^ 32'hA5A5_0000;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .fetch_fault(fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic row(input int i, input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr, input logic ef);
    tv[i] = '{r, rdy, rv, rpc, ev, epc, eaddr, ef};
  endtask

  initial begin
    for (int i = 0; i < 6; i++) row(i, 0, 1, 0, 0, i >= 2, 32'(4 * (i - 2)), 32'(4 * i), 0);
    for (int i = 6; i < 11; i++) row(i, 0, 0, 0, 0, 1, 32'h10, 32'h18, 0);
    row(11, 0, 1, 0, 0, 1, 32'h10, 32'h18, 0);
    row(12, 0, 1, 0, 0, 1, 32'h14, 32'h1C, 0);
    row(13, 0, 1, 0, 0, 1, 32'h18, 32'h20, 0);
    row(14, 0, 0, 0, 0, 1, 32'h1C, 32'h24, 0);
    row(15, 0, 0, 1, 32'h100, 1, 32'h1C, 32'h24, 0);
    row(16, 0, 1, 0, 0, 0, 0, 32'h100, 0);
    row(17, 0, 1, 0, 0, 0, 0, 32'h104, 0);
    row(18, 0, 1, 0, 0, 1, 32'h100, 32'h108, 0);
    row(19, 0, 1, 1, 32'hFFFF_FFF8, 1, 32'h104, 32'h10C, 0);
    row(20, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0);
    row(21, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    row(22, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 0);
    row(23, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h4, 0);
    row(24, 0, 1, 0, 0, 1, 32'h0, 32'h8, 0);
    row(25, 1, 0, 0, 0, 1, 32'h4, 32'hC, 0);
    row(26, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    row(27, 0, 1, 0, 0, 0, 0, 32'h4, 0);
    row(28, 0, 1, 0, 0, 1, 32'h0, 32'h8, 0);
    row(29, 0, 1, 1, 32'h102, 1, 32'h4, 32'hC, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 30; i < 34; i++) row(i, 0, 1, 0, 0, 0, 0, 32'h100, 1);
    row(34, 1, 0, 0, 0, 0, 0, 32'h100, 1);
`else
    row(30, 0, 1, 0, 0, 0, 0, 32'h100, 0);
    row(31, 0, 1, 0, 0, 0, 0, 32'h104, 0);
    row(32, 0, 1, 0, 0, 1, 32'h100, 32'h108, 0);
    row(33, 0, 1, 0, 0, 1, 32'h104, 32'h10C, 0);
    row(34, 1, 0, 0, 0, 1, 32'h108, 32'h110, 0);
`endif
    row(35, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    row(36, 0, 1, 0, 0, 0, 0, 32'h4, 0);
    row(37, 0, 1, 0, 0, 1, 32'h0, 32'h8, 0);

    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    chk("reset dec_valid", 32'(dec_valid), 0);
    chk("reset imem_addr", imem_addr, 0);
    chk("reset dec_pc", dec_pc, 0);
    chk("reset dec_instr", dec_instr, 0);
    chk("reset fetch_fault", 32'(fetch_fault), 0);

    for (int i = 0; i < 38; i++) begin
      rst = tv[i].rst; dec_ready = tv[i].rdy; redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      if (tv[i].ev && tv[i].rdy && !tv[i].rst) sb.push_back(tv[i].epc);
      #1;
      chk($sformatf("row%0d dec_valid", i), 32'(dec_valid), 32'(tv[i].ev));
      chk($sformatf("row%0d imem_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("row%0d fetch_fault", i), 32'(fetch_fault), 32'(tv[i].ef));
      if (tv[i].ev) chk($sformatf("row%0d dec_pc", i), dec_pc, tv[i].epc);
      if (dec_valid && dec_ready && !rst) begin
        if (sb.size() == 0) chk($sformatf("row%0d unexpected xfer pc", i), dec_pc, 32'hDEAD_BEEF);
        else begin
          exp_pc = sb.pop_front();
          chk($sformatf("row%0d xfer pc", i), dec_pc, exp_pc);
          chk($sformatf("row%0d xfer instr", i), dec_instr, exp_pc ^ 32'hA5A5_0000);
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0; rst = 1'b0;
    chk("table scoreboard drained", 32'(sb.size()), 0);

    exp_pc = 32'h4;
    for (int c = 0; c < 300; c++) begin
      dec_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rand fetch-ahead bound", 32'(imem_addr - exp_pc <= 32'd8), 1);
      if (dec_valid && dec_ready) begin
        chk("rand xfer pc", dec_pc, exp_pc);
        chk("rand xfer instr", dec_instr, exp_pc ^ 32'hA5A5_0000);
        exp_pc += 32'd4;
      end
      @(negedge clk);
    end

    dec_ready = 1'b1;
    begin
      int wait_c = 0;
      #1;
      while (!dec_valid && wait_c < 4) begin
        @(negedge clk); #1; wait_c++;
      end
      chk("resume within budget", 32'(dec_valid), 1);
      for (int c = 0; c < 8 && dec_valid; c++) begin
        chk("resume back-to-back pc", dec_pc, exp_pc);
        exp_pc += 32'd4;
        @(negedge clk); #1;
      end
      chk("resume no gap", 32'(dec_valid), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
